instr_mem_loader: RTL and testbench

- Writer side of the instruction-memory load port of the fetch stage.
- Receives a byte stream from the debug UART receiver and writes each byte into instruction memory at consecutive addresses.
- Holds the PC in reset while loading.
- Stops on the HALT word (32'hFFFFFFFF) or when memory is full, then reports completion and the instruction count.

---
 rtl/loader_pkg.sv | 15 +
 rtl/halt_detector.sv | 47 ++++
 rtl/instr_mem_loader.sv | 142 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and
// the word/HALT framing constants used by the top and the halt detector.
package loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } loader_state_t;

    localparam logic [31:0] HALT_WORD      = 32'hFFFF_FFFF;
    localparam int          BYTES_PER_WORD = 4;
    localparam int          BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/halt_detector.sv
// Tracks the byte position inside the current word and whether every byte of
// that word so far equals HALT_BYTE; flags word completion and HALT words.
module halt_detector
    import loader_pkg::*;
#(
    parameter int          MEM_SIZE  = 8,
    parameter logic [MEM_SIZE-1:0] HALT_BYTE = HALT_WORD[MEM_SIZE-1:0]
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [MEM_SIZE-1:0]   byte_data,
    output logic                  word_done,
    output logic                  halt_word
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    logic [BYTE_IDX_W-1:0] byte_idx;
    logic                  halt_match;
    logic                  byte_is_halt;

    assign byte_is_halt = (byte_data == HALT_BYTE);
    assign word_done    = byte_valid && (byte_idx == LAST_IDX);
    // A word is HALT only when all earlier bytes matched and this last one does too.
    assign halt_word    = word_done && halt_match && byte_is_halt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx   <= '0;
            halt_match <= 1'b0;
        end else if (clear) begin
            byte_idx   <= '0;
            halt_match <= 1'b1;
        end else if (byte_valid) begin
            if (byte_idx == LAST_IDX) begin
                byte_idx   <= '0;
                halt_match <= 1'b1;
            end else begin
                byte_idx   <= byte_idx + BYTE_IDX_W'(1);
                halt_match <= halt_match && byte_is_halt;
            end
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Writes a received byte stream into instruction memory at consecutive
// addresses, holding the PC in reset until a HALT word or a full memory.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int                  INSTMEM_SIZE = 8,
    parameter int                  MEM_SIZE     = 8,
    parameter logic [MEM_SIZE-1:0] HALT_BYTE    = HALT_WORD[MEM_SIZE-1:0]
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [MEM_SIZE-1:0]       i_rx_data,
    input  logic                      i_rx_valid,
    output logic                      o_instrmem_en,
    output logic                      o_write_en,
    output logic [MEM_SIZE-1:0]       o_write_data,
    output logic [INSTMEM_SIZE-1:0]   o_write_addr,
    output logic                      o_pc_reset,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_overflow,
    output logic [INSTMEM_SIZE-2:0]   o_instr_count
);

    localparam int                      CNT_W     = INSTMEM_SIZE - 1;
    localparam logic [INSTMEM_SIZE-1:0] ADDR_LAST = '1;

    loader_state_t state, state_next;

    logic [INSTMEM_SIZE-1:0] addr;
    logic                    start_load;
    logic                    accept;
    logic                    word_done;
    logic                    halt_word;
    logic                    end_pending;
    logic                    end_overflow;

    halt_detector #(
        .MEM_SIZE  (MEM_SIZE),
        .HALT_BYTE (HALT_BYTE)
    ) u_halt_detector (
        .clk        (i_clock),
        .rst        (i_reset),
        .clear      (start_load),
        .byte_valid (accept),
        .byte_data  (i_rx_data),
        .word_done  (word_done),
        .halt_word  (halt_word)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The final write is registered, so DONE is entered one cycle later via
    // end_pending; no further bytes are taken during that cycle.
    always_comb begin
        state_next    = state;
        start_load    = 1'b0;
        accept        = 1'b0;
        o_busy        = 1'b0;
        o_pc_reset    = 1'b0;
        o_instrmem_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    start_load = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                o_busy        = 1'b1;
                o_pc_reset    = 1'b1;
                o_instrmem_en = 1'b1;
                accept        = i_rx_valid && !end_pending;
                if (end_pending) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_start) begin
                    start_load = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            addr          <= '0;
            o_write_en    <= 1'b0;
            o_write_data  <= '0;
            o_write_addr  <= '0;
            o_done        <= 1'b0;
            o_overflow    <= 1'b0;
            o_instr_count <= '0;
            end_pending   <= 1'b0;
            end_overflow  <= 1'b0;
        end else begin
            o_write_en <= 1'b0;
            if (start_load) begin
                addr          <= '0;
                o_done        <= 1'b0;
                o_overflow    <= 1'b0;
                o_instr_count <= '0;
                end_pending   <= 1'b0;
                end_overflow  <= 1'b0;
            end else if (accept) begin
                o_write_en   <= 1'b1;
                o_write_data <= i_rx_data;
                o_write_addr <= addr;
                addr         <= addr + INSTMEM_SIZE'(1);
                if (word_done) begin
                    o_instr_count <= o_instr_count + CNT_W'(1);
                    // HALT wins over memory-full when both land on the last word.
                    if (halt_word) begin
                        end_pending  <= 1'b1;
                        end_overflow <= 1'b0;
                    end else if (addr == ADDR_LAST) begin
                        end_pending  <= 1'b1;
                        end_overflow <= 1'b1;
                    end
                end
            end
            if (state == ST_LOAD && end_pending) begin
                end_pending <= 1'b0;
                o_done      <= 1'b1;
                o_overflow  <= end_overflow;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: every accepted byte pushes its expected
// {addr,data} write, popped and compared on the following cycle.
module tb_instr_mem_loader;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int CW = AW - 1;

    logic          i_clock    = 1'b0;
    logic          i_reset    = 1'b1;
    logic          i_start    = 1'b0;
    logic [DW-1:0] i_rx_data  = '0;
    logic          i_rx_valid = 1'b0;
    logic          o_instrmem_en;
    logic          o_write_en;
    logic [DW-1:0] o_write_data;
    logic [AW-1:0] o_write_addr;
    logic          o_pc_reset;
    logic          o_busy;
    logic          o_done;
    logic          o_overflow;
    logic [CW-1:0] o_instr_count;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic          pending    = 1'b0;
    logic [AW-1:0] model_addr = '0;

    instr_mem_loader #(
        .INSTMEM_SIZE (AW),
        .MEM_SIZE     (DW),
        .HALT_BYTE    (8'hFF)
    ) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_rx_data     (i_rx_data),
        .i_rx_valid    (i_rx_valid),
        .o_instrmem_en (o_instrmem_en),
        .o_write_en    (o_write_en),
        .o_write_data  (o_write_data),
        .o_write_addr  (o_write_addr),
        .o_pc_reset    (o_pc_reset),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_overflow    (o_overflow),
        .o_instr_count (o_instr_count)
    );

    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_write();
        logic [AW+DW-1:0] e;
        if (pending) begin
            e = exp_q.pop_front();
            chk("write_en", 32'(o_write_en), 32'd1);
            chk("write_addr", 32'(o_write_addr), 32'(e[AW+DW-1:DW]));
            chk("write_data", 32'(o_write_data), 32'(e[DW-1:0]));
        end else begin
            chk("no_write", 32'(o_write_en), 32'd0);
        end
    endtask

    // One cycle: check last cycle's expected write, then drive new inputs.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic s, input logic exp_wr);
        @(negedge i_clock);
        check_write();
        i_rx_valid = v;
        i_rx_data  = d;
        i_start    = s;
        pending    = exp_wr;
        if (exp_wr) begin
            exp_q.push_back({model_addr, d});
            model_addr = model_addr + 8'd1;
        end
    endtask

    task automatic status(input string tag, input logic busy, input logic done,
                          input logic ovf, input int cnt);
        chk({tag, "_busy"}, 32'(o_busy), 32'(busy));
        chk({tag, "_pc_reset"}, 32'(o_pc_reset), 32'(busy));
        chk({tag, "_instrmem_en"}, 32'(o_instrmem_en), 32'(busy));
        chk({tag, "_done"}, 32'(o_done), 32'(done));
        chk({tag, "_overflow"}, 32'(o_overflow), 32'(ovf));
        chk({tag, "_count"}, 32'(o_instr_count), 32'(cnt));
    endtask

    initial begin
        logic [DW-1:0] halt_seq [8];
        logic [DW-1:0] mis_seq  [8];
        halt_seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        mis_seq  = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};

        #12;
        status("reset", 1'b0, 1'b0, 1'b0, 0);
        chk("reset_write_en", 32'(o_write_en), 32'd0);
        chk("reset_write_addr", 32'(o_write_addr), 32'd0);
        chk("reset_write_data", 32'(o_write_data), 32'd0);
        @(negedge i_clock);
        i_reset = 1'b0;

        // Stream of 10 bytes, then reset with a partial word outstanding.
        model_addr = '0;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(i + 1), 1'b0, 1'b1);
            status("stream", 1'b1, 1'b0, 1'b0, i / 4);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        status("partial", 1'b1, 1'b0, 1'b0, 2);
        i_reset = 1'b1;
        #1;
        status("abort", 1'b0, 1'b0, 1'b0, 0);
        chk("abort_write_en", 32'(o_write_en), 32'd0);
        @(negedge i_clock);
        i_reset = 1'b0;

        // HALT termination, then a stray byte in DONE.
        model_addr = '0;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, halt_seq[i], 1'b0, 1'b1);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        status("halt_last", 1'b1, 1'b0, 1'b0, 2);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        status("halt_done", 1'b0, 1'b1, 1'b0, 2);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        status("halt_hold", 1'b0, 1'b1, 1'b0, 2);

        // Reload from DONE; misaligned HALT with an ignored start mid-load.
        model_addr = '0;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, mis_seq[i], (i == 3), 1'b1);
            if (i == 0) status("reload", 1'b1, 1'b0, 1'b0, 0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        status("misaligned", 1'b1, 1'b0, 1'b0, 2);

        // Gapped strobes: one byte every third cycle.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b1);
            step(1'b0, 8'h00, 1'b0, 1'b0);
            step(1'b0, 8'h00, 1'b0, 1'b0);
        end
        status("gapped", 1'b1, 1'b0, 1'b0, 3);

        // Memory-full termination; start coincides with a byte in IDLE.
        @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);
        i_reset = 1'b0;
        model_addr = '0;
        step(1'b1, 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 8'h00, 1'b0, 1'b1);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        status("ovf_last", 1'b1, 1'b0, 1'b0, 64);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        status("ovf_done", 1'b0, 1'b1, 1'b1, 64);

        // HALT on the final word of a full memory; start coincides with a byte in DONE.
        model_addr = '0;
        step(1'b1, 8'h66, 1'b1, 1'b0);
        for (int i = 0; i < 256; i++) begin
            step(1'b1, (i >= 252) ? 8'hFF : 8'h00, 1'b0, 1'b1);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        status("full_halt_last", 1'b1, 1'b0, 1'b0, 64);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        status("full_halt_done", 1'b0, 1'b1, 1'b0, 64);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
